// File: rtl/rr_arb16_if.sv
// Request/grant bundle between the masters and the rr_arb16 arbiter.
// LOCK is present only when RR_ARB16_LOCK_EN is defined.
interface rr_arb16_if;
    logic        EN;
    logic [15:0] REQ;
`ifdef RR_ARB16_LOCK_EN
    logic        LOCK;
`endif
    logic [15:0] GNT;
    logic        GNTV;
    logic [3:0]  GID;
    logic        NONE;

`ifdef RR_ARB16_LOCK_EN
    modport master (output EN, REQ, LOCK, input GNT, GNTV, GID, NONE);
    modport slave  (input EN, REQ, LOCK, output GNT, GNTV, GID, NONE);
`else
    modport master (output EN, REQ, input GNT, GNTV, GID, NONE);
    modport slave  (input EN, REQ, output GNT, GNTV, GID, NONE);
`endif
endinterface

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter: registered one-hot grant, bounded tenure, one-cycle gap.
// Optional tenure extension via LOCK is enabled with `define RR_ARB16_LOCK_EN.
module rr_arb16 #(
    parameter int HOLD_MAX = 16
) (
    input  logic      CK,
    input  logic      CD,
    rr_arb16_if.slave bus
);
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] gnt_q, gnt_nx;
    logic        gntv_q;
    logic [3:0]  gid_q, gid_nx;
    logic [3:0]  ptr_q, ptr_nx;
    logic [7:0]  count_q, count_nx;
    logic        none_q;
    logic        lock;
    logic        found;
    logic [3:0]  pick_idx;
    logic        owner_req;

`ifdef RR_ARB16_LOCK_EN
    assign lock = bus.LOCK;
`else
    assign lock = 1'b0;
`endif

    assign owner_req = bus.REQ[gid_q];

    // Search from ptr upward; scanning downward lets the nearest set bit win.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        for (int k = 15; k >= 0; k--) begin
            if (bus.REQ[ptr_q + 4'(k)]) begin
                found    = 1'b1;
                pick_idx = ptr_q + 4'(k);
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        gid_nx   = gid_q;
        ptr_nx   = ptr_q;
        count_nx = count_q;
        case (state)
            ST_IDLE, ST_GAP: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
                if (bus.EN && found) begin
                    state_nx = ST_GRANT;
                    gnt_nx   = 16'd1 << pick_idx;
                    gid_nx   = pick_idx;
                    count_nx = 8'd1;
                end
            end
            ST_GRANT: begin
                if (!owner_req || (!lock && count_q == HOLD_LIM)) begin
                    state_nx = ST_GAP;
                    gnt_nx   = '0;
                    ptr_nx   = gid_q + 4'd1;
                    count_nx = '0;
                end else if (!lock && count_q != HOLD_LIM) begin
                    count_nx = count_q + 8'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: CD clears everything at once, even mid-grant; there are no memories needing a reset exemption.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state   <= ST_IDLE;
            gnt_q   <= '0;
            gntv_q  <= 1'b0;
            gid_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            none_q  <= 1'b1;
        end else begin
            state   <= state_nx;
            gnt_q   <= gnt_nx;
            gntv_q  <= |gnt_nx;
            gid_q   <= gid_nx;
            ptr_q   <= ptr_nx;
            count_q <= count_nx;
            none_q  <= ~|bus.REQ;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.GNTV = gntv_q;
    assign bus.GID  = gid_q;
    assign bus.NONE = none_q;

    a_onehot:  assert property (@(posedge CK) disable iff (CD) $onehot0(gnt_q));
    a_gntv:    assert property (@(posedge CK) disable iff (CD) gntv_q == (|gnt_q));
    a_no_swap: assert property (@(posedge CK) disable iff (CD) gntv_q |=> (!gntv_q || $stable(gnt_q)));
    a_count:   assert property (@(posedge CK) disable iff (CD) count_q <= HOLD_LIM);
endmodule

// File: tb/tb_rr_arb16.sv
// Self-checking bench for rr_arb16: directed vector table, corner sequences, random vs. model.
// Build with RR_ARB16_LOCK_EN defined to also exercise LOCK.
module tb_rr_arb16;
    localparam int HOLD = 4;

    logic ck = 1'b0;
    logic cd;
    logic lk;
    int   checks = 0;
    int   errors = 0;

    always #5 ck = ~ck;

    rr_arb16_if bus();
`ifdef RR_ARB16_LOCK_EN
    assign bus.LOCK = lk;
`endif

    rr_arb16 #(.HOLD_MAX(HOLD)) dut (.CK(ck), .CD(cd), .bus(bus));

    typedef struct {
        logic [15:0] req;
        logic        en;
        logic [15:0] gnt;
        logic        gntv;
        logic [3:0]  gid;
        logic        none;
    } tv_t;

    tv_t tv[15];

    // Reference model: the owner (or -1), cycles held, rotating start point.
    int m_owner, m_gid, m_ptr, m_tenure;
    bit m_none;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    function automatic void m_reset();
        m_owner  = -1;
        m_gid    = 0;
        m_ptr    = 0;
        m_tenure = 0;
        m_none   = 1'b1;
    endfunction

    function automatic void m_step(input logic [15:0] req, input bit en, input bit lock);
        if (m_owner >= 0) begin
            if (!req[m_owner] || (!lock && m_tenure >= HOLD)) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
            end else if (!lock) begin
                m_tenure++;
            end
        end else if (en && req != 16'h0) begin
            for (int k = 0; k < 16; k++) begin
                if (req[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                    break;
                end
            end
            m_gid    = m_owner;
            m_tenure = 1;
        end
        m_none = (req == 16'h0);
    endfunction

    task automatic m_check(input string tag);
        logic [15:0] eg;
        eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        check({tag, ".gnt"},  32'(bus.GNT),  32'(eg));
        check({tag, ".gntv"}, 32'(bus.GNTV), 32'(m_owner >= 0));
        check({tag, ".gid"},  32'(bus.GID),  32'(m_gid));
        check({tag, ".none"}, 32'(bus.NONE), 32'(m_none));
    endtask

    task automatic do_reset();
        bus.REQ = '0;
        bus.EN  = 1'b0;
        lk      = 1'b0;
        cd      = 1'b1;
        tick();
        tick();
        cd = 1'b0;
        m_reset();
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] eg;
        bit          on;

        tv[0]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0,  1'b1};
        tv[1]  = '{16'h0004, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        tv[2]  = '{16'h0004, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        tv[3]  = '{16'h0004, 1'b1, 16'h0004, 1'b1, 4'd2,  1'b0};
        tv[4]  = '{16'h0004, 1'b0, 16'h0004, 1'b1, 4'd2,  1'b0};
        tv[5]  = '{16'h0004, 1'b0, 16'h0004, 1'b1, 4'd2,  1'b0};
        tv[6]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd2,  1'b1};
        tv[7]  = '{16'h0200, 1'b1, 16'h0200, 1'b1, 4'd9,  1'b0};
        tv[8]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd9,  1'b1};
        tv[9]  = '{16'h8001, 1'b1, 16'h8000, 1'b1, 4'd15, 1'b0};
        tv[10] = '{16'h0001, 1'b1, 16'h0000, 1'b0, 4'd15, 1'b0};
        tv[11] = '{16'h8001, 1'b1, 16'h0001, 1'b1, 4'd0,  1'b0};
        tv[12] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0,  1'b1};
        tv[13] = '{16'h0200, 1'b1, 16'h0200, 1'b1, 4'd9,  1'b0};
        tv[14] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd9,  1'b1};

        // Reset state
        do_reset();
        check("rst.gnt",  32'(bus.GNT),  32'h0);
        check("rst.gntv", 32'(bus.GNTV), 32'h0);
        check("rst.gid",  32'(bus.GID),  32'h0);
        check("rst.none", 32'(bus.NONE), 32'h1);

        // Directed vector table: EN gating, release, wrap 15->0, NONE lag
        for (int i = 0; i < 15; i++) begin
            bus.REQ = tv[i].req;
            bus.EN  = tv[i].en;
            tick();
            check($sformatf("tv%0d.gnt", i),  32'(bus.GNT),  32'(tv[i].gnt));
            check($sformatf("tv%0d.gntv", i), 32'(bus.GNTV), 32'(tv[i].gntv));
            check($sformatf("tv%0d.gid", i),  32'(bus.GID),  32'(tv[i].gid));
            check($sformatf("tv%0d.none", i), 32'(bus.NONE), 32'(tv[i].none));
        end

        // Full rotation with all requesting: HOLD on, 1 off, owners 0..15 then 0
        do_reset();
        bus.EN  = 1'b1;
        bus.REQ = 16'hFFFF;
        for (int t = 0; t <= 80; t++) begin
            tick();
            on = (t % 5) != 4;
            eg = on ? (16'd1 << ((t / 5) % 16)) : 16'h0;
            check($sformatf("rot%0d.gnt", t),  32'(bus.GNT),  32'(eg));
            check($sformatf("rot%0d.gntv", t), 32'(bus.GNTV), 32'(on));
            check($sformatf("rot%0d.gid", t),  32'(bus.GID),  32'((t / 5) % 16));
        end

        // Asynchronous clear mid-grant, then restart from requester 0
        do_reset();
        bus.EN  = 1'b1;
        bus.REQ = 16'hFFFF;
        repeat (21) tick();
        check("midrst.pre_gnt", 32'(bus.GNT), 32'h0010);
        cd = 1'b1;
        #1;
        check("midrst.gnt",  32'(bus.GNT),  32'h0);
        check("midrst.gntv", 32'(bus.GNTV), 32'h0);
        check("midrst.gid",  32'(bus.GID),  32'h0);
        check("midrst.none", 32'(bus.NONE), 32'h1);
        cd = 1'b0;
        tick();
        check("midrst.regrant", 32'(bus.GNT), 32'h0001);

        // Requester drops in the gap cycle and must not be granted
        do_reset();
        bus.EN  = 1'b1;
        bus.REQ = 16'h0003;
        tick(); m_step(bus.REQ, bus.EN, lk); m_check("gapdrop0");
        bus.REQ = 16'h0002;
        tick(); m_step(bus.REQ, bus.EN, lk); m_check("gapdrop1");
        bus.REQ = 16'h0001;
        tick(); m_step(bus.REQ, bus.EN, lk); m_check("gapdrop2");
        check("gapdrop.gnt", 32'(bus.GNT), 32'h0001);

`ifdef RR_ARB16_LOCK_EN
        // LOCK holds a sole requester past HOLD with no gap; timeout resumes after release of LOCK
        do_reset();
        bus.EN  = 1'b1;
        bus.REQ = 16'h0001;
        lk      = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            m_step(bus.REQ, bus.EN, lk);
            check($sformatf("lock%0d.gnt", t), 32'(bus.GNT), 32'h0001);
        end
        lk = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            m_step(bus.REQ, bus.EN, lk);
            check($sformatf("unlock%0d.gnt", t), 32'(bus.GNT), (t < 3) ? 32'h0001 : 32'h0);
        end
`endif

        // Randomized traffic against the reference model
        do_reset();
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 4))
                0:       r = '0;
                1:       r = 16'd1 << $urandom_range(0, 15);
                2:       r = 16'($urandom);
                default: r = r;
            endcase
            bus.REQ = r;
            bus.EN  = ($urandom_range(0, 7) != 0);
`ifdef RR_ARB16_LOCK_EN
            lk = ($urandom_range(0, 9) == 0);
`endif
            tick();
            m_step(bus.REQ, bus.EN, lk);
            m_check($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
